// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: one outstanding imem fetch, PC advance/hold/redirect,
// IF/ID delivery with a one-entry load-use buffer.
module fetch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic [XLEN-1:0]  pc_q,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ld_use_hazard,
  output logic             pc_stall,
  output logic             pc_load,
  output logic [XLEN-1:0]  pc_new,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_instr,
  output logic             if_flush,
  output logic             id_flush,
  output logic [CNT_W-1:0] redirect_cnt
);

  import fetch_pkg::*;

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] buf_q;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] instr;
  logic            kill;
  logic            live_redir;
  logic            unused;

  assign redir_pc   = {ex_target[XLEN-1:2], 2'b00};
  assign live_redir = ex_redirect && (state_q != BOOT);
  assign unused     = ^{ex_target[1:0], pc_q};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (!ex_redirect && imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (!ex_redirect && ld_use_hazard) state_d = HOLD;
          else state_d = REQ;
        end else if (ex_redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      HOLD: begin
        if (ex_redirect || !ld_use_hazard) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    pc_stall       = 1'b1;
    pc_load        = 1'b0;
    if_valid       = 1'b0;
    instr          = XLEN'(NOP);
    kill           = 1'b0;
    unique case (state_q)
      BOOT: ;
      REQ: begin
        imem_req_valid = !ex_redirect;
        if (ex_redirect) begin
          pc_load = 1'b1;
          kill    = 1'b1;
        end
      end
      WAIT: begin
        if (ex_redirect) begin
          kill    = 1'b1;
          pc_load = imem_rsp_valid;
        end else if (imem_rsp_valid && !ld_use_hazard) begin
          if_valid = 1'b1;
          instr    = imem_rdata;
          pc_stall = 1'b0;
        end
      end
      DRAIN: begin
        // the in-flight response is always thrown away here
        if (ex_redirect) begin
          kill    = 1'b1;
          pc_load = imem_rsp_valid;
        end else if (imem_rsp_valid) begin
          pc_load = 1'b1;
        end
      end
      HOLD: begin
        if (ex_redirect) begin
          pc_load = 1'b1;
          kill    = 1'b1;
        end else if (!ld_use_hazard) begin
          if_valid = 1'b1;
          instr    = buf_q;
          pc_stall = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign pc_new   = live_redir ? redir_pc : target_q;
  assign if_instr = nrst ? instr : '0;
  assign if_flush = kill;
  assign id_flush = kill;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      target_q <= '0;
      buf_q    <= '0;
    end else begin
      if (live_redir) target_q <= redir_pc;
      if (state_q == WAIT && imem_rsp_valid &&
          !ex_redirect && ld_use_hazard) begin
        buf_q <= imem_rdata;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk (clk),
    .nrst(nrst),
    .inc (ex_redirect),
    .cnt (redirect_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl with a PC-register model and scoreboard.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rdy, rsp, redir, haz;
  logic [31:0] rdata, tgt, pc;

  logic        req, stall, load, valid, ifl, idl;
  logic [31:0] pnew, instr;
  logic [15:0] cnt;

  logic        s_req, s_stall, s_load, s_valid, s_ifl, s_idl;
  logic [31:0] s_pnew, s_instr;
  logic [1:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst),
    .imem_req_valid(req), .imem_req_ready(rdy),
    .imem_rsp_valid(rsp), .imem_rdata(rdata),
    .pc_q(pc), .ex_redirect(redir), .ex_target(tgt),
    .ld_use_hazard(haz), .pc_stall(stall), .pc_load(load),
    .pc_new(pnew), .if_valid(valid), .if_instr(instr),
    .if_flush(ifl), .id_flush(idl), .redirect_cnt(cnt)
  );

  fetch_ctrl #(.XLEN(32), .CNT_W(2)) dut_small (
    .clk(clk), .nrst(nrst),
    .imem_req_valid(s_req), .imem_req_ready(rdy),
    .imem_rsp_valid(rsp), .imem_rdata(rdata),
    .pc_q(pc), .ex_redirect(redir), .ex_target(tgt),
    .ld_use_hazard(haz), .pc_stall(s_stall), .pc_load(s_load),
    .pc_new(s_pnew), .if_valid(s_valid), .if_instr(s_instr),
    .if_flush(s_ifl), .id_flush(s_idl), .redirect_cnt(s_cnt)
  );

  // PC register driven by the block's stall/load controls
  always @(posedge clk or negedge nrst) begin
    if (!nrst) pc <= 32'h0;
    else if (load) pc <= pnew;
    else if (!stall) pc <= pc + 32'd4;
  end

  typedef struct {
    string       name;
    bit          rst;
    bit          rdy, rsp;
    logic [31:0] rdata;
    bit          redir;
    logic [31:0] tgt;
    bit          haz;
    bit          e_req, e_stall, e_load;
    logic [31:0] e_new;
    bit          e_valid;
    logic [31:0] e_instr;
    bit          e_flush;
    logic [15:0] e_cnt;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    string n, bit rs, bit rd, bit rp, logic [31:0] da,
    bit re, logic [31:0] ta, bit hz,
    bit q, bit st, bit ld, logic [31:0] nw,
    bit vl, logic [31:0] in, bit fl, logic [15:0] ct,
    logic [31:0] p);
    vec_t v;
    v.name = n; v.rst = rs; v.rdy = rd; v.rsp = rp;
    v.rdata = da; v.redir = re; v.tgt = ta; v.haz = hz;
    v.e_req = q; v.e_stall = st; v.e_load = ld;
    v.e_new = nw; v.e_valid = vl; v.e_instr = in;
    v.e_flush = fl; v.e_cnt = ct; v.e_pc = p;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, want);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; rsp = 1'b0; rdata = 32'h0;
    redir = 1'b0; tgt = 32'h0; haz = 1'b0;
  endtask

  // entered at a negedge; leaves at a negedge with nrst released
  task automatic do_reset(string n);
    idle();
    nrst = 1'b0;
    #2;
    chk({n, ".rst_req"}, 32'(req), 32'd0);
    chk({n, ".rst_stall"}, 32'(stall), 32'd1);
    chk({n, ".rst_load"}, 32'(load), 32'd0);
    chk({n, ".rst_new"}, pnew, 32'h0);
    chk({n, ".rst_valid"}, 32'(valid), 32'd0);
    chk({n, ".rst_instr"}, instr, 32'h0);
    chk({n, ".rst_flush"}, {30'd0, ifl, idl}, 32'd0);
    chk({n, ".rst_cnt"}, 32'(cnt), 32'd0);
    chk({n, ".rst_scnt"}, 32'(s_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    if (v.rst) do_reset(v.name);
    rdy = v.rdy; rsp = v.rsp; rdata = v.rdata;
    redir = v.redir; tgt = v.tgt; haz = v.haz;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    chk({e.name, ".req"}, 32'(req), 32'(e.e_req));
    chk({e.name, ".stall"}, 32'(stall), 32'(e.e_stall));
    chk({e.name, ".load"}, 32'(load), 32'(e.e_load));
    chk({e.name, ".new"}, pnew, e.e_new);
    chk({e.name, ".valid"}, 32'(valid), 32'(e.e_valid));
    chk({e.name, ".instr"}, instr, e.e_instr);
    chk({e.name, ".ifl"}, 32'(ifl), 32'(e.e_flush));
    chk({e.name, ".idl"}, 32'(idl), 32'(e.e_flush));
    chk({e.name, ".cnt"}, 32'(cnt), 32'(e.e_cnt));
    if (e.e_req) chk({e.name, ".pc"}, pc, e.e_pc);
    @(negedge clk);
  endtask

  initial begin
    idle();
    // basic fetch stream
    tbl.push_back(mk("s1boot",1,1,0,0,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s1req0",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s1rsp0",0,1,1,32'hA1,0,0,0, 0,0,0,0,1,32'hA1,0,0,0));
    tbl.push_back(mk("s1req4",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,4));
    tbl.push_back(mk("s1rsp4",0,1,1,32'hA2,0,0,0, 0,0,0,0,1,32'hA2,0,0,0));
    tbl.push_back(mk("s1req8",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,8));
    tbl.push_back(mk("s1rsp8",0,1,1,32'hA3,0,0,0, 0,0,0,0,1,32'hA3,0,0,0));
    // redirect while waiting, then drain
    tbl.push_back(mk("s2boot",1,1,0,0,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s2req",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s2red",0,1,0,0,1,32'h100,0, 0,1,0,32'h100,0,NOP,1,0,0));
    tbl.push_back(mk("s2drn",0,1,0,0,0,0,0, 0,1,0,32'h100,0,NOP,0,1,0));
    tbl.push_back(mk("s2drsp",0,1,1,32'h1111,0,0,0, 0,1,1,32'h100,0,NOP,0,1,0));
    tbl.push_back(mk("s2nreq",0,1,0,0,0,0,0, 1,1,0,32'h100,0,NOP,0,1,32'h100));
    // second redirect during drain: latest wins
    tbl.push_back(mk("s2bboot",1,1,0,0,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s2breq",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s2bred1",0,1,0,0,1,32'h100,0, 0,1,0,32'h100,0,NOP,1,0,0));
    tbl.push_back(mk("s2bred2",0,1,0,0,1,32'h300,0, 0,1,0,32'h300,0,NOP,1,1,0));
    tbl.push_back(mk("s2bdrsp",0,1,1,32'h2222,0,0,0, 0,1,1,32'h300,0,NOP,0,2,0));
    tbl.push_back(mk("s2bnreq",0,1,0,0,0,0,0, 1,1,0,32'h300,0,NOP,0,2,32'h300));
    // response and redirect together, unaligned target
    tbl.push_back(mk("s3boot",1,1,0,0,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s3req",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s3both",0,1,1,32'h55,1,32'h203,0, 0,1,1,32'h200,0,NOP,1,0,0));
    tbl.push_back(mk("s3nreq",0,1,0,0,0,0,0, 1,1,0,32'h200,0,NOP,0,1,32'h200));
    // load-use hold for 3 cycles; stray rsp in HOLD ignored
    tbl.push_back(mk("s4boot",1,1,0,0,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s4req",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s4haz1",0,1,1,32'hDEADBEEF,0,0,1, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s4haz2",0,1,1,32'h12345678,0,0,1, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s4haz3",0,1,0,0,0,0,1, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s4rel",0,1,0,0,0,0,0, 0,0,0,0,1,32'hDEADBEEF,0,0,0));
    tbl.push_back(mk("s4nreq",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,4));
    // redirect in HOLD drops buffer
    tbl.push_back(mk("s5boot",1,1,0,0,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s5req",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s5haz",0,1,1,32'hCAFE,0,0,1, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s5red",0,1,0,0,1,32'h400,1, 0,1,1,32'h400,0,NOP,1,0,0));
    tbl.push_back(mk("s5nreq",0,1,0,0,0,0,0, 1,1,0,32'h400,0,NOP,0,1,32'h400));
    // redirect in REQ, ready low, hazard without rsp
    tbl.push_back(mk("s7boot",1,1,0,0,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    tbl.push_back(mk("s7red",0,1,0,0,1,32'h80,0, 0,1,1,32'h80,0,NOP,1,0,0));
    tbl.push_back(mk("s7nrdy",0,0,0,0,0,0,0, 1,1,0,32'h80,0,NOP,0,1,32'h80));
    tbl.push_back(mk("s7req",0,1,0,0,0,0,0, 1,1,0,32'h80,0,NOP,0,1,32'h80));
    tbl.push_back(mk("s7whaz",0,1,0,0,0,0,1, 0,1,0,32'h80,0,NOP,0,1,0));
    tbl.push_back(mk("s7rsp",0,1,1,32'h77,0,0,0, 0,0,0,32'h80,1,32'h77,0,1,0));
    tbl.push_back(mk("s7nreq",0,1,0,0,0,0,0, 1,1,0,32'h80,0,NOP,0,1,32'h84));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // saturation with CNT_W=2, then reset mid-WAIT
    apply(mk("s6boot",1,1,0,0,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    for (int k = 0; k < 5; k++) begin
      apply(mk($sformatf("s6red%0d", k),0,1,0,0,1,32'((k + 1) * 16),0,
               0,1,1,32'((k + 1) * 16),0,NOP,1,16'(k),0));
    end
    chk("s6.small_sat", 32'(s_cnt), 32'd3);
    apply(mk("s6req",0,1,0,0,0,0,0, 1,1,0,32'h50,0,NOP,0,5,32'h50));
    chk("s6.small_hold", 32'(s_cnt), 32'd3);
    chk("s6.small_req", 32'(s_req), 32'd0);
    do_reset("s6mid");
    apply(mk("s6late",0,1,1,32'hBAD,0,0,0, 0,1,0,0,0,NOP,0,0,0));
    apply(mk("s6nreq",0,1,0,0,0,0,0, 1,1,0,0,0,NOP,0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
